pixel_scan_ctrl: RTL and testbench

Frame scan controller that sequences one pass of the pixel-processing datapath over an image buffer. On start it walks every pixel in raster order and issues reads to the synchronous RGB image memory. It forwards each returned pixel downstream with valid/ready flow control and frame/line markers. At frame start it latches the threshold configuration used by the downstream threshold stage.

---
 rtl/pixel_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pixel_scan_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_ctrl.sv
// Raster-order frame scan controller: issues image memory reads, buffers the
// returned pixels in a 2-entry FIFO and forwards them with sof/eol/eof markers.
module pixel_scan_ctrl #(
  parameter int HEIGHT        = 768,
  parameter int WIDTH         = 512,
  parameter int ADDR_W        = 19,
  parameter int DEF_THRESHOLD = 90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        thr_in,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_r,
  input  logic [7:0]        mem_g,
  input  logic [7:0]        mem_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic [7:0]        thr_cfg,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Handshake: a pixel transfers on every rising edge where pix_valid and
  // pix_ready are both high; pix_valid never drops and the pixel never changes
  // until that transfer happens (only abort or reset withdraw it).

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        thr_q, thr_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        mk_q, mk_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [26:0]       fifo_q [2];
  logic [26:0]       fifo_d [2];

  logic       pop, push, kill, rd_en, last_col, last_pix;
  logic [2:0] occ;
  logic [26:0] head;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    thr_d      = thr_q;
    fifo_d     = fifo_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;

    last_col = (col_q == COL_W'(WIDTH - 1));
    last_pix = last_col && (row_q == ROW_W'(HEIGHT - 1));
    kill     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && abort;
    pop      = (cnt_q != 2'd0) && pix_ready;
    push     = inflight_q && !kill;
    // Slots already claimed by buffered pixels and the read in flight; a pop
    // this cycle hands its slot straight to the next read.
    occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en    = (state_q == S_RUN) && !abort && (occ < 3'd2);

    inflight_d = rd_en;
    mk_d       = {(row_q == '0) && (col_q == '0), last_col, last_pix};

    if (kill) begin
      cnt_d = 2'd0;
      wp_d  = 1'b0;
      rp_d  = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wp_q] = {mem_r, mem_g, mem_b, mk_q};
        wp_d         = ~wp_q;
      end
      if (pop) rp_d = ~rp_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    if (rd_en) begin
      addr_d = addr_q + 1'b1;
      if (last_pix) begin
        row_d  = '0;
        col_d  = '0;
        addr_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          thr_d   = thr_in;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (abort) state_d = S_DONE;
        else if (rd_en && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort || (cnt_d == 2'd0)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      thr_q      <= 8'(DEF_THRESHOLD);
      inflight_q <= 1'b0;
      mk_q       <= 3'b000;
      cnt_q      <= 2'd0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      thr_q      <= thr_d;
      inflight_q <= inflight_d;
      mk_q       <= mk_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
    end
  end

  assign head      = pix_valid ? fifo_q[rp_q] : '0;
  assign pix_valid = (cnt_q != 2'd0);
  assign pix_r     = head[26:19];
  assign pix_g     = head[18:11];
  assign pix_b     = head[10:3];
  assign pix_sof   = head[2];
  assign pix_eol   = head[1];
  assign pix_eof   = head[0];
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign thr_cfg   = thr_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Self-checking bench for pixel_scan_ctrl: a 2x3 frame instance driven with
// varied ready patterns, plus a 1x1 instance for the single-pixel corner case.
module tb_pixel_scan_ctrl;

  localparam int H = 2;
  localparam int W = 3;
  localparam int N = H * W;
  localparam int AW = 3;
  localparam int DEF_THR = 90;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // main 2x3 instance
  logic          start, abort, pix_ready;
  logic [7:0]    thr_in;
  logic          mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_r, mem_g, mem_b, pix_r, pix_g, pix_b, thr_cfg;
  logic [1:0]    dbg_state;

  pixel_scan_ctrl #(.HEIGHT(H), .WIDTH(W), .ADDR_W(AW), .DEF_THRESHOLD(DEF_THR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thr_in(thr_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .thr_cfg(thr_cfg),
    .busy(busy), .done(done), .dbg_state(dbg_state));

  // 1x1 instance
  logic       start1, abort1, ready1, rd1, v1, sof1, eol1, eof1, busy1, done1;
  logic [7:0] thr1, mr1, mg1, mb1, r1, g1, b1, thr_cfg1;
  logic [0:0] addr1;
  logic [1:0] dbg1;

  pixel_scan_ctrl #(.HEIGHT(1), .WIDTH(1), .ADDR_W(1), .DEF_THRESHOLD(DEF_THR)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .thr_in(thr1),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_r(mr1), .mem_g(mg1), .mem_b(mb1),
    .pix_valid(v1), .pix_ready(ready1), .pix_r(r1), .pix_g(g1), .pix_b(b1),
    .pix_sof(sof1), .pix_eol(eol1), .pix_eof(eof1), .thr_cfg(thr_cfg1),
    .busy(busy1), .done(done1), .dbg_state(dbg1));

  // synchronous memories: data one cycle after the read strobe
  logic [23:0] img [8];
  logic [23:0] img1;
  always @(posedge clk) begin
    if (mem_rd_en) {mem_r, mem_g, mem_b} <= img[mem_addr];
    if (rd1) {mr1, mg1, mb1} <= img1;
  end

  int vectors = 0;
  int errors  = 0;
  logic [26:0]   exp_q [$];
  logic [26:0]   pix_obs [$];
  logic [AW-1:0] addr_obs [$];
  logic [26:0]   pix1_obs [$];
  int first_rd, first_vld, last_pop, done_cyc, done_cnt, busy_cnt;
  int rd_total, pop_total, occ, max_occ, stall_err, done1_cnt, rd1_cnt;
  bit stall_prev, abort_prev;
  logic [26:0] stall_head, head;

  assign head = {pix_r, pix_g, pix_b, pix_sof, pix_eol, pix_eof};

  // observation recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        addr_obs.push_back(mem_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (pix_valid && first_vld < 0) first_vld = cyc;
      if (pix_valid && pix_ready) begin
        pix_obs.push_back(head);
        last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      occ = rd_total - pop_total;
      if (occ > max_occ) max_occ = occ;
      rd_total  += int'(mem_rd_en);
      pop_total += int'(pix_valid && pix_ready);
      if (abort && busy) begin
        rd_total  = 0;
        pop_total = 0;
      end
      if (stall_prev && !abort_prev && (!pix_valid || head !== stall_head)) stall_err++;
      stall_prev = pix_valid && !pix_ready;
      stall_head = head;
      abort_prev = abort;
      if (v1 && ready1) pix1_obs.push_back({r1, g1, b1, sof1, eol1, eof1});
      if (done1) done1_cnt++;
      if (rd1) rd1_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic clear_mon();
    pix_obs.delete(); addr_obs.delete(); pix1_obs.delete();
    first_rd = -1; first_vld = -1; last_pop = -1; done_cyc = -1;
    done_cnt = 0; busy_cnt = 0; rd_total = 0; pop_total = 0; max_occ = 0;
    stall_err = 0; stall_prev = 1'b0; abort_prev = 1'b0; done1_cnt = 0; rd1_cnt = 0;
  endtask

  // reference frame: raster order, markers from position within the frame
  task automatic load_image();
    exp_q.delete();
    for (int k = 0; k < 8; k++) img[k] = 24'($urandom);
    for (int k = 0; k < N; k++)
      exp_q.push_back({img[k], k == 0, (k % W) == W - 1, k == N - 1});
  endtask

  task automatic start_frame(input logic [7:0] thr);
    @(posedge clk); #1;
    start = 1'b1; thr_in = thr;
    @(posedge clk); #1;
    start = 1'b0; thr_in = 8'h00;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic wait_done(input int mode, input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ((i % 3) == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({mem_rd_en, pix_valid, busy, done, pix_sof, pix_eol, pix_eof} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000000", {mem_rd_en, pix_valid, busy, done, pix_sof, pix_eol, pix_eof});
    end
    vectors++;
    if ({mem_addr, pix_r, pix_g, pix_b} !== '0) begin
      errors++; $display("FAIL reset_data got addr=%0d rgb=%h%h%h want 0", mem_addr, pix_r, pix_g, pix_b);
    end
    vectors++;
    if (thr_cfg !== 8'(DEF_THR)) begin
      errors++; $display("FAIL reset_thr got %0d want %0d", thr_cfg, DEF_THR);
    end
  endtask

  task automatic test_full_rate();
    bit ok;
    int s;
    clear_mon(); load_image();
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; thr_in = 8'h40; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL full_done got timeout want done pulse"); end
    vectors++;
    if (thr_cfg !== 8'h40) begin errors++; $display("FAIL full_thr got %h want 40", thr_cfg); end
    vectors++;
    if (pix_obs.size() != N) begin errors++; $display("FAIL full_count got %0d want %0d", pix_obs.size(), N); end
    for (int k = 0; k < N && k < pix_obs.size(); k++) begin
      vectors++;
      if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL full_pix[%0d] got %h want %h", k, pix_obs[k], exp_q[k]); end
    end
    for (int k = 0; k < N && k < addr_obs.size(); k++) begin
      vectors++;
      if (addr_obs[k] !== AW'(k)) begin errors++; $display("FAIL full_addr[%0d] got %0d want %0d", k, addr_obs[k], k); end
    end
    vectors++;
    if (first_rd != s + 1) begin errors++; $display("FAIL rd_latency got %0d want %0d", first_rd - s, 1); end
    vectors++;
    if (first_vld != first_rd + 2) begin errors++; $display("FAIL vld_latency got %0d want 2", first_vld - first_rd); end
    vectors++;
    if (done_cyc != last_pop + 1) begin errors++; $display("FAIL done_timing got %0d want 1", done_cyc - last_pop); end
    vectors++;
    if (busy_cnt != N + 2) begin errors++; $display("FAIL busy_cycles got %0d want %0d", busy_cnt, N + 2); end
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_idle got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_ready_toggle();
    bit ok;
    clear_mon(); load_image();
    start_frame(8'h40);
    wait_done(1, 200, ok);
    vectors++;
    if (!ok || pix_obs.size() != N) begin errors++; $display("FAIL toggle_count got %0d (done=%0d) want %0d", pix_obs.size(), ok, N); end
    for (int k = 0; k < N && k < pix_obs.size(); k++) begin
      vectors++;
      if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL toggle_pix[%0d] got %h want %h", k, pix_obs[k], exp_q[k]); end
    end
    vectors++;
    if (stall_err != 0) begin errors++; $display("FAIL toggle_stable got %0d changes want 0", stall_err); end
    vectors++;
    if (max_occ > 2) begin errors++; $display("FAIL toggle_occ got %0d want <=2", max_occ); end
  endtask

  task automatic test_stall_start();
    bit ok;
    clear_mon(); load_image();
    pix_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; thr_in = 8'h40;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    vectors++;
    if (addr_obs.size() != 2) begin errors++; $display("FAIL stall_reads got %0d want 2", addr_obs.size()); end
    vectors++;
    if (pix_valid !== 1'b1 || stall_err != 0) begin errors++; $display("FAIL stall_hold got valid=%b changes=%0d want 1 0", pix_valid, stall_err); end
    wait_done(0, 100, ok);
    vectors++;
    if (!ok || addr_obs.size() != N) begin errors++; $display("FAIL stall_total got %0d want %0d", addr_obs.size(), N); end
    for (int k = 0; k < N && k < addr_obs.size(); k++) begin
      vectors++;
      if (addr_obs[k] !== AW'(k)) begin errors++; $display("FAIL stall_addr[%0d] got %0d want %0d", k, addr_obs[k], k); end
    end
    for (int k = 0; k < N && k < pix_obs.size(); k++) begin
      vectors++;
      if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL stall_pix[%0d] got %h want %h", k, pix_obs[k], exp_q[k]); end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_mon(); load_image();
    pix_ready = 1'b0;
    start_frame(8'h40);
    @(posedge clk); #1;
    start = 1'b1; thr_in = 8'h10;
    @(posedge clk); #1;
    start = 1'b0; thr_in = 8'h00;
    vectors++;
    if (thr_cfg !== 8'h40) begin errors++; $display("FAIL ign_thr_busy got %h want 40", thr_cfg); end
    wait_done(1, 200, ok);
    vectors++;
    if (!ok || done_cnt != 1 || pix_obs.size() != N) begin
      errors++; $display("FAIL ign_frame got done=%0d pix=%0d want 1 %0d", done_cnt, pix_obs.size(), N);
    end
    vectors++;
    if (thr_cfg !== 8'h40) begin errors++; $display("FAIL ign_thr got %h want 40", thr_cfg); end
  endtask

  task automatic test_abort();
    bit ok;
    int rd_before;
    clear_mon(); load_image();
    pix_ready = 1'b1;
    start_frame(8'h55);
    for (int i = 0; i < 50 && pix_obs.size() < 3; i++) begin @(posedge clk); #1; end
    rd_before = addr_obs.size();
    abort = 1'b1; pix_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if (pix_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_next got valid=%b done=%b busy=%b want 0 1 0", pix_valid, done, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got done=%b busy=%b want 0 0", done, busy); end
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (addr_obs.size() != rd_before || done_cnt != 1 || pix_obs.size() != 3) begin
      errors++; $display("FAIL abort_counts got reads=%0d/%0d done=%0d pix=%0d want %0d 1 3", addr_obs.size(), rd_before, done_cnt, pix_obs.size(), rd_before);
    end
    for (int k = 0; k < 3 && k < pix_obs.size(); k++) begin
      vectors++;
      if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL abort_pix[%0d] got %h want %h", k, pix_obs[k], exp_q[k]); end
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL abort_in_idle got done=%0d busy=%b want 1 0", done_cnt, busy); end
    clear_mon(); load_image();
    start_frame(8'h66);
    wait_done(0, 100, ok);
    vectors++;
    if (!ok || pix_obs.size() != N || addr_obs.size() != N) begin
      errors++; $display("FAIL rescan_count got pix=%0d reads=%0d want %0d", pix_obs.size(), addr_obs.size(), N);
    end
    vectors++;
    if (addr_obs.size() == 0 || addr_obs[0] !== '0) begin errors++; $display("FAIL rescan_addr0 got %0d reads want first addr 0", addr_obs.size()); end
    for (int k = 0; k < N && k < pix_obs.size(); k++) begin
      vectors++;
      if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL rescan_pix[%0d] got %h want %h", k, pix_obs[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon(); load_image();
    pix_ready = 1'b0;
    start_frame(8'h77);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_rd_en, pix_valid, busy, done, pix_sof, pix_eol, pix_eof} !== 7'b0 || mem_addr !== '0 || pix_r !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outputs got rd=%b v=%b busy=%b done=%b addr=%0d r=%h want zeros", mem_rd_en, pix_valid, busy, done, mem_addr, pix_r);
    end
    vectors++;
    if (thr_cfg !== 8'(DEF_THR)) begin errors++; $display("FAIL rst_mid_thr got %0d want %0d", thr_cfg, DEF_THR); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    vectors++;
    if (done_cnt != 0 || busy !== 1'b0 || addr_obs.size() != 2) begin
      errors++; $display("FAIL rst_mid_quiet got done=%0d busy=%b reads=%0d want 0 0 2", done_cnt, busy, addr_obs.size());
    end
  endtask

  task automatic test_single_pixel();
    clear_mon();
    img1 = 24'($urandom);
    @(posedge clk); #1;
    start1 = 1'b1; thr1 = 8'h21;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 30 && done1_cnt == 0; i++) begin @(posedge clk); #1; end
    vectors++;
    if (pix1_obs.size() != 1 || done1_cnt != 1 || rd1_cnt != 1) begin
      errors++; $display("FAIL one_counts got pix=%0d done=%0d reads=%0d want 1 1 1", pix1_obs.size(), done1_cnt, rd1_cnt);
    end
    vectors++;
    if (pix1_obs.size() == 0 || pix1_obs[0] !== {img1, 3'b111}) begin
      errors++; $display("FAIL one_pixel got %0d pixels want %h", pix1_obs.size(), {img1, 3'b111});
    end
    vectors++;
    if (thr_cfg1 !== 8'h21) begin errors++; $display("FAIL one_thr got %h want 21", thr_cfg1); end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [7:0] t;
    for (int f = 0; f < 4; f++) begin
      clear_mon(); load_image();
      t = 8'($urandom);
      start_frame(t);
      wait_done(2, 300, ok);
      vectors++;
      if (!ok || pix_obs.size() != N || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_count got pix=%0d done=%0d want %0d 1", f, pix_obs.size(), done_cnt, N);
      end
      for (int k = 0; k < N && k < pix_obs.size(); k++) begin
        vectors++;
        if (pix_obs[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_pix[%0d] got %h want %h", f, k, pix_obs[k], exp_q[k]); end
      end
      vectors++;
      if (thr_cfg !== t || stall_err != 0 || max_occ > 2) begin
        errors++; $display("FAIL rand%0d_misc got thr=%h stall=%0d occ=%0d want %h 0 <=2", f, thr_cfg, stall_err, max_occ, t);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1; thr_in = 8'h00;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; thr1 = 8'h00;
    clear_mon();
    for (int k = 0; k < 8; k++) img[k] = '0;
    img1 = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_full_rate();
    test_ready_toggle();
    test_stall_start();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_single_pixel();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want $finish");
    $fatal(1, "watchdog");
  end

endmodule
